id_exe_ctrl: RTL and testbench

Decode-stage control unit with the ID/EXE pipeline register for the 5-stage core. It turns the 6-bit opcode into the EXE_CMD that drives the ALU, plus the memory, writeback and branch controls. It also detects load-use hazards and applies branch flushes. All outputs except `stall` are registered and feed the EXE stage.

---
 rtl/id_exe_ctrl.sv | 177 +++++++++++++++++
 tb/tb_id_exe_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/id_exe_ctrl.sv
// ID-stage control decode plus the ID/EXE pipeline register.
// Decodes the opcode into ALU/memory/writeback/branch controls, detects
// load-use hazards against the instruction in EXE, and inserts bubbles on
// stall, flush or an empty IF/ID slot.
module id_exe_ctrl #(
    parameter int unsigned OPC_LEN      = 6,
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned EXE_CMD_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [OPC_LEN-1:0]      opcode,
    input  logic [REG_ADDR_LEN-1:0] src1,
    input  logic [REG_ADDR_LEN-1:0] src2,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic                    flush,
    input  logic                    exe_mem_r_en,
    input  logic [REG_ADDR_LEN-1:0] exe_dest,
    output logic                    stall,
    output logic [EXE_CMD_LEN-1:0]  exe_cmd,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic                    wb_en,
    output logic                    is_imm,
    output logic [1:0]              br_type,
    output logic [REG_ADDR_LEN-1:0] dest_out,
    output logic                    valid_out
);

    localparam logic [OPC_LEN-1:0] OP_ADD  = 6'b000001;
    localparam logic [OPC_LEN-1:0] OP_SUB  = 6'b000011;
    localparam logic [OPC_LEN-1:0] OP_AND  = 6'b000101;
    localparam logic [OPC_LEN-1:0] OP_OR   = 6'b000110;
    localparam logic [OPC_LEN-1:0] OP_NOR  = 6'b000111;
    localparam logic [OPC_LEN-1:0] OP_XOR  = 6'b001000;
    localparam logic [OPC_LEN-1:0] OP_SLA  = 6'b001001;
    localparam logic [OPC_LEN-1:0] OP_SLL  = 6'b001010;
    localparam logic [OPC_LEN-1:0] OP_SRA  = 6'b001011;
    localparam logic [OPC_LEN-1:0] OP_SRL  = 6'b001100;
    localparam logic [OPC_LEN-1:0] OP_ADDI = 6'b100000;
    localparam logic [OPC_LEN-1:0] OP_SUBI = 6'b100001;
    localparam logic [OPC_LEN-1:0] OP_LD   = 6'b100100;
    localparam logic [OPC_LEN-1:0] OP_ST   = 6'b100101;
    localparam logic [OPC_LEN-1:0] OP_BEZ  = 6'b101000;
    localparam logic [OPC_LEN-1:0] OP_BNE  = 6'b101001;
    localparam logic [OPC_LEN-1:0] OP_JMP  = 6'b101010;

    localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = 4'b0000;
    localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = 4'b0010;
    localparam logic [EXE_CMD_LEN-1:0] CMD_AND = 4'b0100;
    localparam logic [EXE_CMD_LEN-1:0] CMD_OR  = 4'b0101;
    localparam logic [EXE_CMD_LEN-1:0] CMD_NOR = 4'b0110;
    localparam logic [EXE_CMD_LEN-1:0] CMD_XOR = 4'b0111;
    localparam logic [EXE_CMD_LEN-1:0] CMD_SHL = 4'b1000;
    localparam logic [EXE_CMD_LEN-1:0] CMD_SRA = 4'b1001;
    localparam logic [EXE_CMD_LEN-1:0] CMD_SRL = 4'b1010;

    logic [EXE_CMD_LEN-1:0] dec_cmd;
    logic                   dec_imm;
    logic                   dec_rd;
    logic                   dec_wr;
    logic                   dec_wb;
    logic [1:0]             dec_br;
    logic                   use_src1;
    logic                   use_src2;
    logic                   load_instr;

    // Opcode decode; unlisted opcodes fall through as a NOP with no source use.
    always_comb begin
        dec_cmd  = CMD_ADD;
        dec_imm  = 1'b0;
        dec_rd   = 1'b0;
        dec_wr   = 1'b0;
        dec_wb   = 1'b0;
        dec_br   = 2'b00;
        use_src1 = 1'b0;
        use_src2 = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
            OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
                dec_wb   = 1'b1;
                use_src1 = 1'b1;
                use_src2 = 1'b1;
                case (opcode)
                    OP_SUB:         dec_cmd = CMD_SUB;
                    OP_AND:         dec_cmd = CMD_AND;
                    OP_OR:          dec_cmd = CMD_OR;
                    OP_NOR:         dec_cmd = CMD_NOR;
                    OP_XOR:         dec_cmd = CMD_XOR;
                    OP_SLA, OP_SLL: dec_cmd = CMD_SHL;
                    OP_SRA:         dec_cmd = CMD_SRA;
                    OP_SRL:         dec_cmd = CMD_SRL;
                    default:        dec_cmd = CMD_ADD;
                endcase
            end
            OP_ADDI: begin
                dec_imm  = 1'b1;
                dec_wb   = 1'b1;
                use_src1 = 1'b1;
            end
            OP_SUBI: begin
                dec_cmd  = CMD_SUB;
                dec_imm  = 1'b1;
                dec_wb   = 1'b1;
                use_src1 = 1'b1;
            end
            OP_LD: begin
                dec_imm  = 1'b1;
                dec_rd   = 1'b1;
                dec_wb   = 1'b1;
                use_src1 = 1'b1;
            end
            OP_ST: begin
                dec_imm  = 1'b1;
                dec_wr   = 1'b1;
                use_src1 = 1'b1;
                use_src2 = 1'b1;
            end
            OP_BEZ: begin
                dec_br   = 2'b01;
                use_src1 = 1'b1;
            end
            OP_BNE: begin
                dec_br   = 2'b10;
                use_src1 = 1'b1;
                use_src2 = 1'b1;
            end
            OP_JMP: begin
                dec_br   = 2'b11;
            end
            default: begin
            end
        endcase
    end

    // Load-use hazard: r0 never creates a dependency, and a flush squashes ID anyway.
    always_comb begin
        stall = instr_valid && exe_mem_r_en && (exe_dest != '0) && !flush &&
                ((use_src1 && (src1 == exe_dest)) || (use_src2 && (src2 == exe_dest)));
    end

    assign load_instr = instr_valid && !flush && !stall;

    // ID/EXE register: decoded controls for a live instruction, otherwise a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_cmd   <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en     <= 1'b0;
            is_imm    <= 1'b0;
            br_type   <= 2'b00;
            dest_out  <= '0;
            valid_out <= 1'b0;
        end else if (load_instr) begin
            exe_cmd   <= dec_cmd;
            mem_r_en  <= dec_rd;
            mem_w_en  <= dec_wr;
            wb_en     <= dec_wb && (dest_in != '0);
            is_imm    <= dec_imm;
            br_type   <= dec_br;
            dest_out  <= dest_in;
            valid_out <= 1'b1;
        end else begin
            exe_cmd   <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en     <= 1'b0;
            is_imm    <= 1'b0;
            br_type   <= 2'b00;
            dest_out  <= '0;
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_exe_ctrl.sv
// Randomized self-checking bench for id_exe_ctrl against a table-driven model.
module tb_id_exe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [5:0] opcode;
    logic [4:0] src1, src2, dest_in, exe_dest;
    logic       flush, exe_mem_r_en;
    logic       stall;
    logic [3:0] exe_cmd;
    logic       mem_r_en, mem_w_en, wb_en, is_imm, valid_out;
    logic [1:0] br_type;
    logic [4:0] dest_out;

    always #5 clk = ~clk;

    id_exe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .src1         (src1),
        .src2         (src2),
        .dest_in      (dest_in),
        .flush        (flush),
        .exe_mem_r_en (exe_mem_r_en),
        .exe_dest     (exe_dest),
        .stall        (stall),
        .exe_cmd      (exe_cmd),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .wb_en        (wb_en),
        .is_imm       (is_imm),
        .br_type      (br_type),
        .dest_out     (dest_out),
        .valid_out    (valid_out)
    );

    // One row per instruction: opcode, ALU command, flags, branch type, source use.
    typedef struct {
        logic [5:0] opc;
        logic [3:0] cmd;
        bit         imm, rd, wr, wb;
        logic [1:0] br;
        bit         u1, u2;
    } op_t;

    op_t ops[17];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] outs();
        return {valid_out, exe_cmd, mem_r_en, mem_w_en, wb_en, is_imm, br_type, dest_out};
    endfunction

    function automatic void model(input logic iv, input logic [5:0] opc,
                                  input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [4:0] d, input logic fl, input logic er,
                                  input logic [4:0] ed, output logic st,
                                  output logic [15:0] nxt);
        int k;
        k = -1;
        for (int i = 0; i < 17; i++) if (ops[i].opc == opc) k = i;
        st = 1'b0;
        if (iv && er && ed != 0 && !fl && k >= 0)
            st = (ops[k].u1 && s1 == ed) || (ops[k].u2 && s2 == ed);
        if (!iv || fl || st) nxt = '0;
        else if (k < 0) nxt = {1'b1, 10'b0, d};
        else nxt = {1'b1, ops[k].cmd, ops[k].rd, ops[k].wr, ops[k].wb && d != 0,
                    ops[k].imm, ops[k].br, d};
    endfunction

    // Drive one ID-stage cycle (called at posedge+1), check stall mid-cycle and
    // the registered result just after the next rising edge.
    task automatic cycle(input string tag, input logic iv, input logic [5:0] opc,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic fl, input logic er, input logic [4:0] ed);
        logic        st;
        logic [15:0] nxt;
        instr_valid = iv; opcode = opc; src1 = s1; src2 = s2; dest_in = d;
        flush = fl; exe_mem_r_en = er; exe_dest = ed;
        model(iv, opc, s1, s2, d, fl, er, ed, st, nxt);
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall), 32'(st));
        @(posedge clk);
        #1;
        check({tag, "_out"}, 32'(outs()), 32'(nxt));
    endtask

    function automatic op_t mk(input logic [5:0] opc, input logic [3:0] cmd, input bit imm,
                               input bit rd, input bit wr, input bit wb,
                               input logic [1:0] br, input bit u1, input bit u2);
        op_t o;
        o.opc = opc; o.cmd = cmd; o.imm = imm; o.rd = rd; o.wr = wr; o.wb = wb;
        o.br = br; o.u1 = u1; o.u2 = u2;
        return o;
    endfunction

    initial begin
        ops[0]  = mk(6'b000001, 4'b0000, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[1]  = mk(6'b000011, 4'b0010, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[2]  = mk(6'b000101, 4'b0100, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[3]  = mk(6'b000110, 4'b0101, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[4]  = mk(6'b000111, 4'b0110, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[5]  = mk(6'b001000, 4'b0111, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[6]  = mk(6'b001001, 4'b1000, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[7]  = mk(6'b001010, 4'b1000, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[8]  = mk(6'b001011, 4'b1001, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[9]  = mk(6'b001100, 4'b1010, 0, 0, 0, 1, 2'b00, 1, 1);
        ops[10] = mk(6'b100000, 4'b0000, 1, 0, 0, 1, 2'b00, 1, 0);
        ops[11] = mk(6'b100001, 4'b0010, 1, 0, 0, 1, 2'b00, 1, 0);
        ops[12] = mk(6'b100100, 4'b0000, 1, 1, 0, 1, 2'b00, 1, 0);
        ops[13] = mk(6'b100101, 4'b0000, 1, 0, 1, 0, 2'b00, 1, 1);
        ops[14] = mk(6'b101000, 4'b0000, 0, 0, 0, 0, 2'b01, 1, 0);
        ops[15] = mk(6'b101001, 4'b0000, 0, 0, 0, 0, 2'b10, 1, 1);
        ops[16] = mk(6'b101010, 4'b0000, 0, 0, 0, 0, 2'b11, 0, 0);

        // Reset held while a valid ADD is presented: outputs stay clear across edges.
        rst = 1'b1; instr_valid = 1'b1; opcode = 6'b000001; src1 = 5'd1; src2 = 5'd2;
        dest_in = 5'd3; flush = 1'b0; exe_mem_r_en = 1'b0; exe_dest = 5'd0;
        #2 rst = 1'b0;
        #1 check("reset_async", 32'(outs()), 32'h0);
        @(posedge clk); #1;
        check("reset_held", 32'(outs()), 32'h0);
        rst = 1'b1;
        cycle("post_reset_add", 1, 6'b000001, 5'd1, 5'd2, 5'd3, 0, 0, 5'd0);

        // Opcode sweep plus one unlisted opcode.
        for (int i = 0; i < 17; i++)
            cycle($sformatf("sweep_%0d", i), 1, ops[i].opc, 5'd1, 5'd2, 5'd3, 0, 0, 5'd0);
        cycle("sweep_unlisted", 1, 6'b111111, 5'd1, 5'd2, 5'd3, 0, 0, 5'd0);
        cycle("nop", 1, 6'b000000, 5'd1, 5'd2, 5'd3, 0, 1, 5'd1);

        // Load-use hazards and the zero register.
        cycle("lu_add_src2", 1, 6'b000001, 5'd1, 5'd5, 5'd3, 0, 1, 5'd5);
        cycle("lu_redecode", 1, 6'b000001, 5'd1, 5'd5, 5'd3, 0, 0, 5'd5);
        cycle("lu_addi_src2", 1, 6'b100000, 5'd1, 5'd5, 5'd3, 0, 1, 5'd5);
        cycle("lu_addi_src1", 1, 6'b100000, 5'd5, 5'd1, 5'd3, 0, 1, 5'd5);
        cycle("lu_jmp", 1, 6'b101010, 5'd5, 5'd5, 5'd3, 0, 1, 5'd5);
        cycle("r0_hazard", 1, 6'b000001, 5'd0, 5'd2, 5'd3, 0, 1, 5'd0);
        cycle("r0_dest", 1, 6'b000001, 5'd1, 5'd2, 5'd0, 0, 0, 5'd0);
        cycle("lu_not_load", 1, 6'b000001, 5'd5, 5'd2, 5'd3, 0, 0, 5'd5);
        cycle("flush_vs_stall", 1, 6'b000001, 5'd5, 5'd2, 5'd3, 1, 1, 5'd5);
        cycle("flush_plain", 1, 6'b100100, 5'd1, 5'd2, 5'd3, 1, 0, 5'd0);
        cycle("invalid", 0, 6'b000001, 5'd5, 5'd2, 5'd3, 0, 1, 5'd5);

        // Asynchronous reset between edges, then restart.
        cycle("pre_midreset", 1, 6'b100100, 5'd1, 5'd2, 5'd7, 0, 0, 5'd0);
        #3 rst = 1'b0;
        #1 check("midcycle_reset", 32'(outs()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle("restart_idle", 0, 6'b000001, 5'd1, 5'd2, 5'd3, 0, 0, 5'd0);
        cycle("restart_first", 1, 6'b000011, 5'd1, 5'd2, 5'd4, 0, 0, 5'd0);

        // Random traffic; small register range so hazards occur often.
        for (int n = 0; n < 300; n++) begin
            logic [5:0] opc;
            if ($urandom_range(0, 9) < 8) opc = ops[$urandom_range(0, 16)].opc;
            else opc = 6'($urandom_range(0, 63));
            cycle("rand", ($urandom_range(0, 7) != 0), opc,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
